xact_axi_resp: RTL and testbench
================================

# xact_axi_resp

AXI4 slave responder model for the bandwidth-monitor environment: the responder end of the AXI links whose master side is observed by the bandwidth monitors. It accepts AR/AW/W, returns R and B after a fixed, parameterised latency, and generates address-derived read data, so measured bandwidth depends only on master behaviour and the programmed latency. It sits behind each monitored master port in place of real fabric.

## Interface
- ID_W, 4: AXI ID width.
- ADDR_W, 32: address width, minimum 32.
- DATA_W, 64: data width, multiple of 32.
- OSTD, 4: outstanding depth per direction (AR queue, AW queue, B queue); power of 2, 2..16.
- RD_LAT, 8: cycles from AR handshake to first R beat; 1..65535.
- WR_LAT, 4: cycles from WLAST handshake to BVALID; 1..65535.

- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- awid/awaddr/awlen/awsize/awvalid  in  ID_W/ADDR_W/8/3/1  write address channel.
- awready  out  1
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data; data and strobe ignored.
- wready  out  1
- bid/bresp/bvalid  out  ID_W/2/1;  bready  in  1
- arid/araddr/arlen/arsize/arvalid  in  ID_W/ADDR_W/8/3/1
- arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1;  rready  in  1
- err_wlast  out  1  sticky: WLAST disagreed with AWLEN.
- rd_ostd, wr_ostd  out  $clog2(OSTD)+1  current AR-queue / (AW+B)-queue occupancy.

## Operation
- Free-running 16-bit cycle counter `now`; wraps mod 2^16. Every queue entry stores `ts` = `now` at its push.
- Entry is ripe when (now - ts) mod 2^16 >= latency; modular subtraction makes wrap harmless.
- Read path: arready = AR queue not full. Handshake pushes {id, addr, len, size, ts}. R engine states IDLE -> BURST. IDLE: head valid and ripe (RD_LAT) -> BURST, beat=0. BURST: rvalid=1, rid=head id, rlast=(beat==len); rvalid/rdata/rlast held stable while rready=0. Beat handshake increments beat; last-beat handshake pops head and returns to IDLE, or stays in BURST with beat=0 when the next head is already ripe (no bubble).
- rdata: beat address A = addr + beat*(1<<size), low 32 bits, replicated across DATA_W/32 lanes. All bursts treated as INCR.
- Write path: awready = AW queue not full. wready = AW queue not empty and B queue not full. W beats counted against AW head len; the beat with count==len ends the burst regardless of wlast, pops AW head and pushes {id, resp, ts} into B queue. err_wlast set if wlast != (count==len) on any W handshake; cleared only by reset.
- B path: bvalid when B-queue head ripe (WR_LAT); pop on bready handshake; next head may present the following cycle.
- rresp/bresp = 2'b00 unless error feature enabled.
- Simultaneous push and pop on a full queue: pop frees space only for the next cycle (ready uses registered occupancy).

## Timing
- During reset and until first edge after release all outputs 0; ready outputs 1 from the first cycle after aresetn rises (queues empty).
- AR handshake at cycle t -> first rvalid at cycle t+RD_LAT; with rready=1, burst of len+1 beats on consecutive cycles.
- WLAST handshake at cycle t -> bvalid at t+WR_LAT.
- Reset asserted mid-burst: queues, engine and err_wlast clear immediately; no partial response after release.

## Configuration
- XACT_AXI_RESP_ERR_EN defined: transactions with address bit ADDR_W-1 set respond 2'b10 (SLVERR) on every R beat and on B; timing unchanged.
- Undefined: all responses OKAY; address bit ignored.

## Test plan
- Single read: arid=3, araddr=0x1000, arlen=3, arsize=3, rready=1 -> rvalid at t+8, rdata lanes 0x1000, 0x1008, 0x1010, 0x1018, rlast on 4th beat, rid=3.
- Read backpressure: 5 ARs issued back-to-back -> arready low after 4th; rready toggled 1/0 -> data held stable, no beat lost, rd_ostd returns to 0.
- Single write: awlen=1, two W beats, wlast on 2nd -> bvalid at t+4, bid matches, err_wlast=0.
- WLAST mismatch: awlen=2, wlast on beat 1 -> burst still ends after 3 beats, err_wlast=1 and stays 1.
- Counter wrap: issue AR at now=0xFFFC -> rvalid exactly RD_LAT cycles later.
- With XACT_AXI_RESP_ERR_EN: araddr=0x8000_0000 -> rresp=2'b10 all beats; without macro -> 2'b00.

Source files
------------

// File: rtl/xact_axi_resp.sv
// AXI4 slave responder: fixed-latency R/B responses with address-derived read data.
// Optional XACT_AXI_RESP_ERR_EN: address MSB set -> SLVERR on R and B.
module xact_axi_resp #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int OSTD   = 4,
    parameter int RD_LAT = 8,
    parameter int WR_LAT = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_W-1:0]         awid,
    input  logic [ADDR_W-1:0]       awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W/8-1:0]     wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_W-1:0]         bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_W-1:0]         arid,
    input  logic [ADDR_W-1:0]       araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_W-1:0]         rid,
    output logic [DATA_W-1:0]       rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    err_wlast,
    output logic [$clog2(OSTD):0]   rd_ostd,
    output logic [$clog2(OSTD):0]   wr_ostd
);
    localparam int PW    = $clog2(OSTD);
    localparam int CW    = PW + 1;
    localparam int LANES = DATA_W / 32;

    typedef enum logic { R_IDLE, R_BURST } r_state_t;

    logic [15:0] now;
    logic        rdy_en;

    logic unused;
    assign unused = ^{wdata, wstrb, awsize, awaddr, araddr};

    logic ar_err_in, aw_err_in;
`ifdef XACT_AXI_RESP_ERR_EN
    assign ar_err_in = araddr[ADDR_W-1];
    assign aw_err_in = awaddr[ADDR_W-1];
`else
    assign ar_err_in = 1'b0;
    assign aw_err_in = 1'b0;
`endif

    // queue storage (no reset; validity tracked by counters)
    logic [ID_W-1:0] ar_id_q   [OSTD];
    logic [31:0]     ar_addr_q [OSTD];
    logic [7:0]      ar_len_q  [OSTD];
    logic [2:0]      ar_size_q [OSTD];
    logic [15:0]     ar_ts_q   [OSTD];
    logic            ar_err_q  [OSTD];
    logic [ID_W-1:0] aw_id_q   [OSTD];
    logic [7:0]      aw_len_q  [OSTD];
    logic            aw_err_q  [OSTD];
    logic [ID_W-1:0] b_id_q    [OSTD];
    logic [15:0]     b_ts_q    [OSTD];
    logic            b_err_q   [OSTD];

    logic [PW-1:0] ar_wp, ar_rp, aw_wp, aw_rp, b_wp, b_rp;
    logic [CW-1:0] ar_cnt, aw_cnt, b_cnt;

    r_state_t r_state, r_nxt;
    logic [7:0] beat, beat_nxt;
    logic [7:0] wcnt;
    logic ar_push, ar_pop, aw_push, aw_pop, b_push, b_pop, w_hs, w_end;
    logic ar_ripe, b_ripe, r_last_c;
    logic [15:0] ar_age, b_age;

    assign arready = rdy_en && (ar_cnt != CW'(OSTD));
    assign awready = rdy_en && (aw_cnt != CW'(OSTD));
    assign wready  = rdy_en && (aw_cnt != '0) && (b_cnt != CW'(OSTD));

    assign ar_push = arvalid && arready;
    assign aw_push = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign w_end   = w_hs && (wcnt == aw_len_q[aw_rp]);
    assign aw_pop  = w_end;
    assign b_push  = w_end;

    // modular age keeps ripeness correct across the 16-bit wrap of now
    assign ar_age  = now - ar_ts_q[ar_rp];
    assign b_age   = now - b_ts_q[b_rp];
    assign ar_ripe = (ar_cnt != '0) && (ar_age >= 16'(RD_LAT));
    assign b_ripe  = (b_cnt != '0) && (b_age >= 16'(WR_LAT));

    assign r_last_c = (beat == ar_len_q[ar_rp]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            now    <= '0;
            rdy_en <= 1'b0;
            ar_wp  <= '0;  ar_rp  <= '0;  ar_cnt <= '0;
            aw_wp  <= '0;  aw_rp  <= '0;  aw_cnt <= '0;
            b_wp   <= '0;  b_rp   <= '0;  b_cnt  <= '0;
            r_state   <= R_IDLE;
            beat      <= '0;
            wcnt      <= '0;
            err_wlast <= 1'b0;
        end else begin
            now    <= now + 16'd1;
            rdy_en <= 1'b1;
            if (ar_push) ar_wp <= ar_wp + 1'b1;
            if (ar_pop)  ar_rp <= ar_rp + 1'b1;
            if (aw_push) aw_wp <= aw_wp + 1'b1;
            if (aw_pop)  aw_rp <= aw_rp + 1'b1;
            if (b_push)  b_wp  <= b_wp + 1'b1;
            if (b_pop)   b_rp  <= b_rp + 1'b1;
            ar_cnt <= ar_cnt + CW'(ar_push) - CW'(ar_pop);
            aw_cnt <= aw_cnt + CW'(aw_push) - CW'(aw_pop);
            b_cnt  <= b_cnt + CW'(b_push) - CW'(b_pop);
            r_state <= r_nxt;
            beat    <= beat_nxt;
            if (w_end)     wcnt <= '0;
            else if (w_hs) wcnt <= wcnt + 8'd1;
            if (w_hs && (wlast != (wcnt == aw_len_q[aw_rp]))) err_wlast <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (ar_push) begin
            ar_id_q[ar_wp]   <= arid;
            ar_addr_q[ar_wp] <= araddr[31:0];
            ar_len_q[ar_wp]  <= arlen;
            ar_size_q[ar_wp] <= arsize;
            ar_ts_q[ar_wp]   <= now;
            ar_err_q[ar_wp]  <= ar_err_in;
        end
        if (aw_push) begin
            aw_id_q[aw_wp]  <= awid;
            aw_len_q[aw_wp] <= awlen;
            aw_err_q[aw_wp] <= aw_err_in;
        end
        if (b_push) begin
            b_id_q[b_wp]  <= aw_id_q[aw_rp];
            b_ts_q[b_wp]  <= now;
            b_err_q[b_wp] <= aw_err_q[aw_rp];
        end
    end

    // IDLE presents beat 0 as soon as the head ripens; BURST holds it from then on,
    // so a ripe follow-on head after a last beat is presented without a bubble.
    always_comb begin
        r_nxt    = r_state;
        beat_nxt = beat;
        rvalid   = 1'b0;
        ar_pop   = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_ripe) begin
                    rvalid = 1'b1;
                    if (!rready)       r_nxt = R_BURST;
                    else if (r_last_c) ar_pop = 1'b1;
                    else begin
                        r_nxt    = R_BURST;
                        beat_nxt = beat + 8'd1;
                    end
                end
            end
            R_BURST: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (r_last_c) begin
                        ar_pop   = 1'b1;
                        beat_nxt = '0;
                        r_nxt    = R_IDLE;
                    end else begin
                        beat_nxt = beat + 8'd1;
                    end
                end
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    logic [31:0] r_addr;
    assign r_addr = rvalid ? (ar_addr_q[ar_rp] + (32'(beat) << ar_size_q[ar_rp])) : '0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign rdata[g*32 +: 32] = r_addr;
    end

    assign rid   = rvalid ? ar_id_q[ar_rp] : '0;
    assign rlast = rvalid && r_last_c;
    assign rresp = (rvalid && ar_err_q[ar_rp]) ? 2'b10 : 2'b00;

    assign bvalid = b_ripe;
    assign b_pop  = bvalid && bready;
    assign bid    = bvalid ? b_id_q[b_rp] : '0;
    assign bresp  = (bvalid && b_err_q[b_rp]) ? 2'b10 : 2'b00;

    // AW+B can exceed the port width when both queues are full; saturate
    logic [CW:0] wr_sum;
    assign wr_sum  = {1'b0, aw_cnt} + {1'b0, b_cnt};
    assign wr_ostd = wr_sum[CW] ? '1 : wr_sum[CW-1:0];
    assign rd_ostd = ar_cnt;
endmodule

// File: tb/tb_xact_axi_resp.sv
// Directed self-checking bench for xact_axi_resp (default parameters).
module tb_xact_axi_resp;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready;
    logic [63:0] wdata = '0, rdata;
    logic [7:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready = 0, arvalid = 0, arready, rlast, rvalid, rready = 0;
    logic        err_wlast;
    logic [2:0]  rd_ostd, wr_ostd;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] now_ref;
    logic [1:0]  exp_err;

    xact_axi_resp dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .err_wlast(err_wlast), .rd_ostd(rd_ostd), .wr_ostd(wr_ostd)
    );

    always #5 aclk = ~aclk;

    // cycle reference used only to place the wrap test
    always @(posedge aclk or negedge aresetn)
        if (!aresetn) now_ref <= '0;
        else          now_ref <= now_ref + 16'd1;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rvalid(input string tag, input int budget);
        int n = 0;
        while (!rvalid && n < budget) begin tick(); n++; end
        chk(tag, {63'd0, rvalid}, 64'd1);
    endtask

    task automatic wait_bvalid(input string tag, input int budget);
        int n = 0;
        while (!bvalid && n < budget) begin tick(); n++; end
        chk(tag, {63'd0, bvalid}, 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        int k;
        int seen;
`ifdef XACT_AXI_RESP_ERR_EN
        exp_err = 2'b10;
`else
        exp_err = 2'b00;
`endif
        // reset state
        tick(); tick();
        chk("rst_outs", {56'd0, arready, awready, wready, rvalid, bvalid, err_wlast, rlast, 1'b0}, 64'd0);
        chk("rst_ostd", {58'd0, rd_ostd, wr_ostd}, 64'd0);
        aresetn = 1'b1;
        chk("rel_arready0", {63'd0, arready}, 64'd0);
        tick();
        chk("rdy_after_rel", {61'd0, arready, awready, wready}, 64'b110);

        // single read: rvalid RD_LAT cycles after the AR handshake
        rready = 1'b1;
        arid = 4'd3; araddr = 32'h1000; arlen = 8'd3; arsize = 3'd3; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("rd1_ostd", {61'd0, rd_ostd}, 64'd1);
        repeat (6) tick();
        chk("rd1_early", {63'd0, rvalid}, 64'd0);
        tick();
        chk("rd1_valid", {63'd0, rvalid}, 64'd1);
        for (int b = 0; b < 4; b++) begin
            a = 32'h1000 + 32'(b) * 32'd8;
            chk($sformatf("rd1_data%0d", b), rdata, {a, a});
            chk($sformatf("rd1_id_last%0d", b), {59'd0, rid, rlast}, {59'd0, 4'd3, b == 3});
            chk($sformatf("rd1_resp%0d", b), {62'd0, rresp}, 64'd0);
            tick();
        end
        chk("rd1_done", {60'd0, rvalid, rd_ostd}, 64'd0);

        // read backpressure: 4 accepted, 5th refused; rready toggled
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            arid = 4'(i); araddr = 32'h2000 + 32'(i) * 32'h100; arlen = 8'd1; arsize = 3'd2;
            arvalid = 1'b1;
            chk($sformatf("bp_arready%0d", i), {63'd0, arready}, {63'd0, i < 4});
            if (i < 4) tick();
        end
        arvalid = 1'b0;
        chk("bp_ostd_full", {61'd0, rd_ostd}, 64'd4);
        wait_rvalid("bp_first_valid", 20);
        repeat (3) begin
            chk("bp_hold", rdata, {32'h2000, 32'h2000});
            tick();
        end
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            rready = c[0];
            if (rvalid) begin
                a = 32'h2000 + 32'(k / 2) * 32'h100 + 32'(k % 2) * 32'd4;
                chk($sformatf("bp_data%0d", k), rdata, {a, a});
                if (rready) begin
                    chk($sformatf("bp_id_last%0d", k), {59'd0, rid, rlast}, {59'd0, 4'(k / 2), k[0]});
                    k++;
                end
            end
            tick();
        end
        rready = 1'b0;
        chk("bp_beats", 64'(k), 64'd8);
        chk("bp_ostd_empty", {60'd0, rvalid, rd_ostd}, 64'd0);

        // single write: bvalid WR_LAT cycles after WLAST handshake
        bready = 1'b1;
        awid = 4'd5; awaddr = 32'h3000; awlen = 8'd1; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wr1_wready", {63'd0, wready}, 64'd1);
        wvalid = 1'b1; wlast = 1'b0;
        tick();
        wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("wr1_ostd", {61'd0, wr_ostd}, 64'd1);
        repeat (2) tick();
        chk("wr1_early", {63'd0, bvalid}, 64'd0);
        tick();
        chk("wr1_b", {57'd0, bvalid, bid, bresp}, {57'd0, 1'b1, 4'd5, 2'b00});
        tick();
        chk("wr1_done", {59'd0, bvalid, wr_ostd, err_wlast}, 64'd0);

        // WLAST on the wrong beat: burst still ends on AWLEN
        awid = 4'd6; awlen = 8'd2; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wlast = 1'b0;
        tick();
        wlast = 1'b1;
        tick();
        chk("wl_err_set", {63'd0, err_wlast}, 64'd1);
        chk("wl_still_open", {62'd0, wready, 1'b0}, 64'b10);
        wlast = 1'b0;
        tick();
        wvalid = 1'b0;
        chk("wl_ended", {63'd0, wready}, 64'd0);
        wait_bvalid("wl_bvalid", 10);
        chk("wl_bid", {60'd0, bid}, 64'd6);
        tick();
        chk("wl_sticky", {63'd0, err_wlast}, 64'd1);

        // error-address transaction
        rready = 1'b1;
        arid = 4'd1; araddr = 32'h8000_0000; arlen = 8'd1; arsize = 3'd3; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        wait_rvalid("err_rvalid", 20);
        chk("err_r0", {rresp, rdata[61:0]}, {exp_err, 62'h0000_0000_0000_0000 | {30'd0, 32'h8000_0000}});
        tick();
        chk("err_r1", {62'd0, rresp}, {62'd0, exp_err});
        chk("err_r1_data", rdata, {32'h8000_0008, 32'h8000_0008});
        tick();
        awid = 4'd2; awaddr = 32'h8000_0000; awlen = 8'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        wait_bvalid("err_bvalid", 10);
        chk("err_bresp", {62'd0, bresp}, {62'd0, exp_err});
        tick();

        // reset mid-burst clears everything, no response afterwards
        arid = 4'd2; araddr = 32'h500; arlen = 8'd7; arsize = 3'd3; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        wait_rvalid("mid_rvalid", 20);
        tick(); tick();
        aresetn = 1'b0;
        #1;
        chk("mid_clear", {59'd0, rvalid, arready, err_wlast, rd_ostd == 3'd0, wr_ostd == 3'd0}, 64'b00011);
        tick(); tick();
        aresetn = 1'b1;
        seen = 0;
        repeat (20) begin tick(); if (rvalid || bvalid) seen++; end
        chk("mid_no_resp", 64'(seen), 64'd0);
        chk("mid_ostd", {61'd0, rd_ostd}, 64'd0);

        // counter wrap: AR issued at now=0xFFFC
        k = 0;
        while (now_ref != 16'hFFFC && k < 70000) begin tick(); k++; end
        chk("wrap_reach", {48'd0, now_ref}, 64'hFFFC);
        arid = 4'd9; araddr = 32'h40; arlen = 8'd0; arsize = 3'd0; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        repeat (6) tick();
        chk("wrap_early", {63'd0, rvalid}, 64'd0);
        tick();
        chk("wrap_valid", {62'd0, rvalid, rlast}, 64'b11);
        chk("wrap_data", rdata, {32'h40, 32'h40});
        tick();
        chk("wrap_done", {63'd0, rvalid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
